ntt_stage_sched: RTL and testbench

//  Sequences a full in-place DIF (Gentleman-Sande) NTT of N=2^LOGN points through one ButterFly

---
 rtl/ntt_stage_sched.sv | 160 ++++++++++++++++
 tb/tb_ntt_stage_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_stage_sched.sv
// rtl/ntt_stage_sched.sv - in-place DIF NTT butterfly scheduler; optional NTT_SCHED_INTT_EN adds inverse twiddle select
module ntt_stage_sched #(
  parameter int LOGN     = 3,
  parameter int RD_LAT   = 1,
  parameter int EVEN_LAT = 7,
  parameter int ODD_LAT  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [15:0]     q_cfg,
`ifdef NTT_SCHED_INTT_EN
  input  logic            inverse,
`endif
  output logic            busy,
  output logic            done,
  output logic [15:0]     q,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr0,
  output logic [LOGN-1:0] rd_addr1,
`ifdef NTT_SCHED_INTT_EN
  output logic [LOGN-1:0] tw_addr,
`else
  output logic [LOGN-2:0] tw_addr,
`endif
  output logic            wr0_en,
  output logic [LOGN-1:0] wr0_addr,
  output logic            wr1_en,
  output logic [LOGN-1:0] wr1_addr
);

  localparam int DRN = RD_LAT + ODD_LAT;
  localparam int D0  = RD_LAT + EVEN_LAT;
  localparam int D1  = RD_LAT + ODD_LAT;
  localparam int SW  = (LOGN > 1) ? $clog2(LOGN) : 1;
  localparam int DW  = $clog2(DRN + 1);
  localparam int TW  = LOGN - 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [SW-1:0]   LAST_S = SW'(LOGN - 1);
  localparam logic [LOGN-2:0] JMAX   = '1;
  localparam logic [LOGN-1:0] ONE    = LOGN'(1);
  localparam logic [DW-1:0]   DLAST  = DW'(DRN - 1);

  logic [1:0]      state;
  logic [SW-1:0]   s;
  logic [LOGN-2:0] j;
  logic [DW-1:0]   dcnt;
`ifdef NTT_SCHED_INTT_EN
  logic            inv_q;
`endif

  logic [LOGN-1:0] j_ext, half, low_mask, k, base;
  logic [TW-1:0]   tw_full, tw_low;

  logic [D0-1:0]   v0_sr;
  logic [D1-1:0]   v1_sr;
  logic [LOGN-1:0] a0_sr [D0];
  logic [LOGN-1:0] a1_sr [D1];

  // Stage/butterfly sequencing: RUN issues N/2 butterflies, DRAIN lets the pipeline empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      s     <= '0;
      j     <= '0;
      dcnt  <= '0;
      q     <= '0;
`ifdef NTT_SCHED_INTT_EN
      inv_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          q     <= q_cfg;
          s     <= '0;
          j     <= '0;
`ifdef NTT_SCHED_INTT_EN
          inv_q <= inverse;
`endif
        end
        RUN: if (j == JMAX) begin
          state <= DRAIN;
          dcnt  <= '0;
        end else begin
          j <= j + 1'b1;
        end
        DRAIN: if (dcnt == DLAST) begin
          dcnt <= '0;
          j    <= '0;
          if (s == LAST_S) begin
            state <= DONE;
          end else begin
            s     <= s + 1'b1;
            state <= RUN;
          end
        end else begin
          dcnt <= dcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address generation with masks: k = j mod half, g*len = (j with low bits cleared) * 2
  always_comb begin
    j_ext    = {1'b0, j};
    half     = ONE << (LAST_S - s);
    low_mask = half - ONE;
    k        = j_ext & low_mask;
    base     = (j_ext & ~low_mask) << 1;
    tw_full  = TW'(k << s);
    tw_low   = (state == RUN) ? tw_full : '0;
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign rd_en    = (state == RUN);
  assign rd_addr0 = rd_en ? (base | k) : '0;
  assign rd_addr1 = rd_en ? (base | k | half) : '0;
`ifdef NTT_SCHED_INTT_EN
  assign tw_addr  = {rd_en & inv_q, tw_low};
`else
  assign tw_addr  = tw_low;
`endif

  // Write-back delay lines: {valid,addr} travel alongside the butterfly pipeline
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v0_sr <= '0;
      v1_sr <= '0;
      for (int i = 0; i < D0; i++) a0_sr[i] <= '0;
      for (int i = 0; i < D1; i++) a1_sr[i] <= '0;
    end else begin
      v0_sr[0] <= rd_en;
      a0_sr[0] <= rd_addr0;
      for (int i = 1; i < D0; i++) begin
        v0_sr[i] <= v0_sr[i-1];
        a0_sr[i] <= a0_sr[i-1];
      end
      v1_sr[0] <= rd_en;
      a1_sr[0] <= rd_addr1;
      for (int i = 1; i < D1; i++) begin
        v1_sr[i] <= v1_sr[i-1];
        a1_sr[i] <= a1_sr[i-1];
      end
    end
  end

  assign wr0_en   = v0_sr[D0-1];
  assign wr0_addr = a0_sr[D0-1];
  assign wr1_en   = v1_sr[D1-1];
  assign wr1_addr = a1_sr[D1-1];

endmodule

// File: tb/tb_ntt_stage_sched.sv
// tb/tb_ntt_stage_sched.sv - self-checking bench for ntt_stage_sched (schedule, data, start/q, reset)
module tb_ntt_stage_sched;

  localparam int LOGN  = 3;
  localparam int N     = 1 << LOGN;
  localparam int H     = N / 2;
  localparam int LE    = 1 + 7;
  localparam int LO    = 1 + 8;
  localparam int DRN   = 9;
  localparam int PER   = H + DRN;
  localparam int TOTAL = LOGN * PER + 1;
`ifdef NTT_SCHED_INTT_EN
  localparam int TWW = LOGN;
`else
  localparam int TWW = LOGN - 1;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [15:0]     q_cfg = '0;
  logic            inverse = 1'b0;
  logic            busy, done, rd_en, wr0_en, wr1_en;
  logic [15:0]     q;
  logic [LOGN-1:0] rd_addr0, rd_addr1, wr0_addr, wr1_addr;
  logic [TWW-1:0]  tw_addr;
  logic [LOGN-2:0] tw_low;

  int n_checks = 0;
  int n_fail   = 0;
  int qv       = 7681;
  int omega;
  int ram    [N];
  int x0     [N];
  int tw_rom [H];

  assign tw_low = tw_addr[LOGN-2:0];

  ntt_stage_sched dut (
    .clk(clk), .reset(reset), .start(start), .q_cfg(q_cfg),
`ifdef NTT_SCHED_INTT_EN
    .inverse(inverse),
`endif
    .busy(busy), .done(done), .q(q), .rd_en(rd_en),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .tw_addr(tw_addr),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr1_en(wr1_en), .wr1_addr(wr1_addr)
  );

  always #5 clk = ~clk;

  function automatic int mulmod(input int a, input int b, input int m);
    longint p;
    p = longint'(a) * longint'(b);
    return int'(p % longint'(m));
  endfunction

  function automatic int powmod(input int b, input int e, input int m);
    int r = 1;
    for (int i = 0; i < e; i++) r = mulmod(r, b, m);
    return r;
  endfunction

  function automatic int bitrev(input int v);
    int r = 0;
    for (int i = 0; i < LOGN; i++) if (((v >> i) & 1) != 0) r |= 1 << (LOGN - 1 - i);
    return r;
  endfunction

  // Reference schedule: which butterfly is read in cycle t after start (t=1 is the first RUN cycle)
  function automatic void ref_read(input int t, output bit v, output int a0, output int a1, output int w);
    int st, off, half, len, k, g;
    v = 0; a0 = 0; a1 = 0; w = 0;
    if (t >= 1 && t <= TOTAL - 1) begin
      st  = (t - 1) / PER;
      off = (t - 1) % PER;
      if (off < H) begin
        half = N >> (st + 1);
        len  = 2 * half;
        k    = off % half;
        g    = off / half;
        a0   = g * len + k;
        a1   = a0 + half;
        w    = (k * (1 << st)) % H;
        v    = 1;
      end
    end
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, rd_en, wr0_en, wr1_en} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, rd_en, wr0_en, wr1_en});
    end
    n_checks++;
    if ({rd_addr0, rd_addr1, wr0_addr, wr1_addr} !== '0 || tw_addr !== '0) begin
      n_fail++; $display("FAIL reset_addr: got %h/%h/%h/%h tw %h want 0", rd_addr0, rd_addr1, wr0_addr, wr1_addr, tw_addr);
    end
    n_checks++;
    if (q !== 16'd0) begin
      n_fail++; $display("FAIL reset_q: got %0d want 0", q);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Cycle-exact run against the reference schedule, with a RAM + butterfly data model
  task automatic test_full_run(input bit hold_start, input bit poke_q);
    bit v, ev0, ev1;
    int a0, a1, w, ea0, ea1, ja, jb, jw, ewt, av, bv, wv;
    int even_q[$];
    int odd_q[$];
    for (int i = 0; i < N; i++) begin
      x0[i]  = int'($urandom_range(0, qv - 1));
      ram[i] = x0[i];
    end
    inverse = 1'($urandom_range(0, 1));
    q_cfg   = 16'(qv);
    start   = 1'b1;
    for (int t = 1; t <= TOTAL + 5; t++) begin
      @(negedge clk);
      ref_read(t, v, a0, a1, w);
      ref_read(t - LE, ev0, ea0, ja, jw);
      ref_read(t - LO, ev1, jb, ea1, jw);
`ifdef NTT_SCHED_INTT_EN
      ewt = v ? ((int'(inverse) << (LOGN - 1)) | w) : 0;
`else
      ewt = w;
`endif
      n_checks++;
      if (busy !== (t <= TOTAL) || done !== (t == TOTAL)) begin
        n_fail++; $display("FAIL busy_done t=%0d: got %b%b want %b%b", t, busy, done, t <= TOTAL, t == TOTAL);
      end
      n_checks++;
      if (rd_en !== v || rd_addr0 !== LOGN'(a0) || rd_addr1 !== LOGN'(a1)) begin
        n_fail++; $display("FAIL read t=%0d: got %b (%0d,%0d) want %b (%0d,%0d)", t, rd_en, rd_addr0, rd_addr1, v, a0, a1);
      end
      n_checks++;
      if (tw_addr !== TWW'(ewt)) begin
        n_fail++; $display("FAIL tw_addr t=%0d: got %0d want %0d", t, tw_addr, ewt);
      end
      n_checks++;
      if (wr0_en !== ev0 || wr0_addr !== LOGN'(ea0)) begin
        n_fail++; $display("FAIL wr0 t=%0d: got %b@%0d want %b@%0d", t, wr0_en, wr0_addr, ev0, ea0);
      end
      n_checks++;
      if (wr1_en !== ev1 || wr1_addr !== LOGN'(ea1)) begin
        n_fail++; $display("FAIL wr1 t=%0d: got %b@%0d want %b@%0d", t, wr1_en, wr1_addr, ev1, ea1);
      end
      n_checks++;
      if (q !== 16'(qv)) begin
        n_fail++; $display("FAIL q t=%0d: got %0d want %0d", t, q, qv);
      end
      if (rd_en === 1'b1) begin
        av = ram[rd_addr0];
        bv = ram[rd_addr1];
        wv = tw_rom[tw_low];
        even_q.push_back((av + bv) % qv);
        odd_q.push_back(mulmod((av - bv + qv) % qv, wv, qv));
      end
      if (wr0_en === 1'b1 && even_q.size() > 0) ram[wr0_addr] = even_q.pop_front();
      if (wr1_en === 1'b1 && odd_q.size() > 0) ram[wr1_addr] = odd_q.pop_front();
      if (!hold_start || t == TOTAL) start = 1'b0;
      if (poke_q && t == 10) q_cfg = 16'($urandom_range(1, 65535));
    end
    start = 1'b0;
  endtask

  // Golden DFT: DIF output lands in bit-reversed order
  task automatic test_transform();
    int xm;
    for (int m = 0; m < N; m++) begin
      xm = 0;
      for (int n = 0; n < N; n++) xm = (xm + mulmod(x0[n], powmod(omega, (n * m) % N, qv), qv)) % qv;
      n_checks++;
      if (ram[bitrev(m)] !== xm) begin
        n_fail++; $display("FAIL ntt_out X[%0d]@%0d: got %0d want %0d", m, bitrev(m), ram[bitrev(m)], xm);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    q_cfg = 16'(qv);
    start = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_checks++;
    if (rd_en !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_run_active: got rd_en=%b busy=%b want 1 1", rd_en, busy);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, rd_en, wr0_en, wr1_en} !== 5'b0 || q !== 16'd0) begin
      n_fail++; $display("FAIL async_reset_ctrl: got %b q=%0d want 00000 q=0", {busy, done, rd_en, wr0_en, wr1_en}, q);
    end
    n_checks++;
    if ({rd_addr0, rd_addr1, wr0_addr, wr1_addr} !== '0 || tw_addr !== '0) begin
      n_fail++; $display("FAIL async_reset_addr: got %h/%h/%h/%h tw %h want 0", rd_addr0, rd_addr1, wr0_addr, wr1_addr, tw_addr);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, rd_en, wr0_en, wr1_en} !== 4'b0) begin
        n_fail++; $display("FAIL post_reset_quiet t=%0d: got %b want 0000", t, {busy, rd_en, wr0_en, wr1_en});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    omega = 0;
    for (int g = 2; g < 100 && omega == 0; g++) begin
      if (powmod(powmod(g, (qv - 1) / N, qv), H, qv) == qv - 1) omega = powmod(g, (qv - 1) / N, qv);
    end
    for (int i = 0; i < H; i++) tw_rom[i] = powmod(omega, i, qv);

    test_reset();
    test_full_run(1'b0, 1'b0);
    test_transform();
    test_full_run(1'b1, 1'b1);
    test_transform();
    test_reset_mid_run();
    test_full_run(1'b0, 1'b0);
    test_transform();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
